bn_stat_sequencer: RTL and testbench

Controller that sequences the BN parameter register bank for one channel.
- Accepts one mini-batch of signed activations over a valid/ready stream.
- Accumulates the running sum and the running min/max.
- Writes the range-based deviation, the mean and the latched gamma/beta into the parameter bank, one valid strobe per cycle in fixed order, then pulses done.
- Sits between the activation stream and the parameter bank.

---
 rtl/bn_stat_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_bn_stat_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_stat_sequencer.sv
// bn_stat_sequencer: per-channel BN statistics sequencer.
// Takes one mini-batch of signed activations over a valid/ready stream and
// keeps the running sum, min and max. It then writes range (max-min), mean,
// gamma and beta to the parameter bank, one strobe per cycle in that order,
// and finally pulses done.
//
// Optional feature: define BN_ABORT_EN to add the abort input and the
// aborted output. Without the macro those ports do not exist.
//
// Handshake: a sample transfers on a rising edge where x_valid && x_ready.
// x_ready is high only in ACCUM. The producer may hold x_valid low for any
// number of cycles. The bank write strobes are single-cycle, there is no
// ready on that side, and each data output is already stable in the cycle
// its strobe is high.
module bn_stat_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MINI_BATCH = 64,
  parameter int ADDR_WIDTH = $clog2(MINI_BATCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] gamma_cfg,
  input  logic [DATA_WIDTH-1:0] beta_cfg,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
`ifdef BN_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  output logic                  x_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sample_cnt,
  output logic [DATA_WIDTH-1:0] stan_dev_o,
  output logic [DATA_WIDTH-1:0] avg_o,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic                  valid_stan_dev,
  output logic                  valid_avg,
  output logic                  valid_gamma,
  output logic                  valid_beta
);

  localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(MINI_BATCH - 1);

  localparam logic signed [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCUM    = 3'd1,
    S_WR_SD    = 3'd2,
    S_WR_AVG   = 3'd3,
    S_WR_GAMMA = 3'd4,
    S_WR_BETA  = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e                        state_q, state_d;
  logic signed [SUM_W-1:0]       sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0]  min_q, min_d;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  cnt_t                          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]         gamma_lat_q, gamma_lat_d;
  logic [DATA_WIDTH-1:0]         beta_lat_q, beta_lat_d;
  logic [DATA_WIDTH-1:0]         sd_q, sd_d;
  logic [DATA_WIDTH-1:0]         avg_q, avg_d;
  logic [DATA_WIDTH-1:0]         gout_q, gout_d;
  logic [DATA_WIDTH-1:0]         bout_q, bout_d;
  logic [DATA_WIDTH:0]           diff;
  logic signed [DATA_WIDTH-1:0]  x_s;
  logic signed [SUM_W-1:0]       x_sext;
  logic                          abort_hit;
  logic                          accept;

  assign x_s    = $signed(x_data);
  assign x_sext = {{ADDR_WIDTH{x_data[DATA_WIDTH-1]}}, x_data};

`ifdef BN_ABORT_EN
  logic aborted_q, aborted_d;

  // Abort only matters while a batch is in flight. In IDLE and DONE it is ignored.
  assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
  assign aborted_d = abort_hit;
  assign aborted   = aborted_q;

  // Register the aborted pulse so that it appears in the first cycle back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end
`else
  assign abort_hit = 1'b0;
`endif

  // A sample is taken only in ACCUM. An abort in the same cycle wins and the sample is dropped.
  assign accept = (state_q == S_ACCUM) && x_valid && !abort_hit;

  // Next-state and datapath updates. Each bank output register is loaded on
  // the edge that enters its write state, so it is stable while its strobe is high.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    gamma_lat_d = gamma_lat_q;
    beta_lat_d  = beta_lat_q;
    sd_d        = sd_q;
    avg_d       = avg_q;
    gout_d      = gout_q;
    bout_d      = bout_q;
    diff        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          gamma_lat_d = gamma_cfg;
          beta_lat_d  = beta_cfg;
          sum_d       = '0;
          cnt_d       = '0;
          min_d       = MAX_POS;
          max_d       = MAX_NEG;
          state_d     = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else if (accept) begin
          sum_d = sum_q + x_sext;
          min_d = (x_s < min_q) ? x_s : min_q;
          max_d = (x_s > max_q) ? x_s : max_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // The range uses min/max after this last sample has been applied.
            // The difference is computed one bit wider. Bit DATA_WIDTH set
            // would mean it does not fit in DATA_WIDTH bits, so clamp to all-ones.
            diff    = {max_d[DATA_WIDTH-1], max_d} - {min_d[DATA_WIDTH-1], min_d};
            sd_d    = diff[DATA_WIDTH] ? '1 : diff[DATA_WIDTH-1:0];
            state_d = S_WR_SD;
          end
        end
      end

      S_WR_SD: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else begin
          // Arithmetic shift right by ADDR_WIDTH is the same as taking the top DATA_WIDTH bits (floor).
          avg_d   = sum_q[SUM_W-1:ADDR_WIDTH];
          state_d = S_WR_AVG;
        end
      end

      S_WR_AVG: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else begin
          gout_d  = gamma_lat_q;
          state_d = S_WR_GAMMA;
        end
      end

      S_WR_GAMMA: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else begin
          bout_d  = beta_lat_q;
          state_d = S_WR_BETA;
        end
      end

      S_WR_BETA: begin
        if (abort_hit) state_d = S_IDLE;
        else           state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, accumulators and output registers. An async reset drops any batch in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      gamma_lat_q <= '0;
      beta_lat_q  <= '0;
      sd_q        <= '0;
      avg_q       <= '0;
      gout_q      <= '0;
      bout_q      <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      gamma_lat_q <= gamma_lat_d;
      beta_lat_q  <= beta_lat_d;
      sd_q        <= sd_d;
      avg_q       <= avg_d;
      gout_q      <= gout_d;
      bout_q      <= bout_d;
    end
  end

  // Strobes and status are decoded from the registered state, so at most one strobe is high at a time.
  assign x_ready        = (state_q == S_ACCUM);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign valid_stan_dev = (state_q == S_WR_SD);
  assign valid_avg      = (state_q == S_WR_AVG);
  assign valid_gamma    = (state_q == S_WR_GAMMA);
  assign valid_beta     = (state_q == S_WR_BETA);

  assign sample_cnt = cnt_q;
  assign stan_dev_o = sd_q;
  assign avg_o      = avg_q;
  assign gamma_o    = gout_q;
  assign beta_o     = bout_q;

endmodule

// File: tb/tb_bn_stat_sequencer.sv
// Testbench for bn_stat_sequencer (DATA_WIDTH=16, MINI_BATCH=64).
// Exercises the BN_ABORT_EN ports only when that macro is defined.
module tb_bn_stat_sequencer;

  localparam int DW = 16;
  localparam int MB = 64;
  localparam int AW = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] gamma_cfg = '0;
  logic [DW-1:0] beta_cfg = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          x_ready, busy, done;
  logic [AW:0]   sample_cnt;
  logic [DW-1:0] stan_dev_o, avg_o, gamma_o, beta_o;
  logic          valid_stan_dev, valid_avg, valid_gamma, valid_beta;
`ifdef BN_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  bn_stat_sequencer #(.DATA_WIDTH(DW), .MINI_BATCH(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .gamma_cfg(gamma_cfg),
    .beta_cfg(beta_cfg),
    .x_valid(x_valid),
    .x_data(x_data),
`ifdef BN_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .x_ready(x_ready),
    .busy(busy),
    .done(done),
    .sample_cnt(sample_cnt),
    .stan_dev_o(stan_dev_o),
    .avg_o(avg_o),
    .gamma_o(gamma_o),
    .beta_o(beta_o),
    .valid_stan_dev(valid_stan_dev),
    .valid_avg(valid_avg),
    .valid_gamma(valid_gamma),
    .valid_beta(valid_beta)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] wr_vec();
    return {valid_stan_dev, valid_avg, valid_gamma, valid_beta, done};
  endfunction

  // Reference model: plain integer statistics over the sample queue.
  task automatic model_push(input logic [DW-1:0] g, input logic [DW-1:0] b);
    int sum, mn, mx, v, mean, rng;
    sum = 0;
    mn  = 1 << 30;
    mx  = -(1 << 30);
    foreach (stim_q[i]) begin
      v = int'($signed(stim_q[i]));
      sum += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    mean = (sum >= 0) ? (sum / MB) : -((-sum + MB - 1) / MB);
    rng  = mx - mn;
    if (rng > 65535) rng = 65535;
    exp_q.push_back(DW'(rng));
    exp_q.push_back(DW'(mean));
    exp_q.push_back(g);
    exp_q.push_back(b);
  endtask

  // ---------------- driver ----------------
  // Runs one batch from stim_q and checks the write phase against exp_q.
  // poke: drive stray start / cfg changes while busy; they must have no effect.
  task automatic run_batch(input string tag, input int stall_pct, input bit poke,
                           input logic [DW-1:0] g, input logic [DW-1:0] b);
    int            idx, cyc;
    logic [DW-1:0] exp4[4];
    logic [DW-1:0] act;
    start     = 1'b1;
    gamma_cfg = g;
    beta_cfg  = b;
    x_valid   = 1'b0;
    step();
    start = 1'b0;
    check({tag, "_busy_accum"}, busy, 1);
    check({tag, "_cnt_start"}, sample_cnt, 0);
    idx = 0;
    cyc = 0;
    while (idx < stim_q.size() && cyc < 2000) begin
      x_valid = ($urandom_range(99) >= stall_pct);
      x_data  = x_valid ? stim_q[idx] : DW'($urandom);
      if (poke) begin
        start     = 1'($urandom_range(1));
        gamma_cfg = DW'($urandom);
        beta_cfg  = DW'($urandom);
      end
      check({tag, "_x_ready_accum"}, x_ready, 1);
      check({tag, "_no_wr_in_accum"}, wr_vec(), 0);
      if (x_valid) idx++;
      step();
      cyc++;
    end
    x_valid = 1'b0;
    start   = 1'b0;
    if (idx < stim_q.size()) begin
      check({tag, "_accum_timeout"}, idx, stim_q.size());
      exp_q.delete();
      return;
    end
    if (exp_q.size() < 4) begin
      check({tag, "_exp_q_short"}, exp_q.size(), 4);
      return;
    end
    for (int k = 0; k < 4; k++) exp4[k] = exp_q.pop_front();
    // Cycles T+1 .. T+4
    for (int k = 0; k < 4; k++) begin
      check({tag, "_strobe"}, wr_vec(), 5'b10000 >> k);
      case (k)
        0:       act = stan_dev_o;
        1:       act = avg_o;
        2:       act = gamma_o;
        default: act = beta_o;
      endcase
      check({tag, (k == 0) ? "_stan_dev" : (k == 1) ? "_avg" : (k == 2) ? "_gamma" : "_beta"},
            act, exp4[k]);
      if (k == 0) begin
        check({tag, "_x_ready_after_last"}, x_ready, 0);
        check({tag, "_cnt_full"}, sample_cnt, MB);
      end
      step();
    end
    // Cycle T+5: done
    check({tag, "_done"}, wr_vec(), 5'b00001);
    check({tag, "_busy_done"}, busy, 1);
    if (poke) begin
      start     = 1'b1;
      gamma_cfg = DW'($urandom);
    end
    step();
    start = 1'b0;
    // Cycle T+6: IDLE, outputs held
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_wr"}, wr_vec(), 0);
    check({tag, "_cnt_hold"}, sample_cnt, MB);
    check({tag, "_sd_hold"}, stan_dev_o, exp4[0]);
    check({tag, "_avg_hold"}, avg_o, exp4[1]);
    check({tag, "_gamma_hold"}, gamma_o, exp4[2]);
    check({tag, "_beta_hold"}, beta_o, exp4[3]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x_ready"}, x_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr"}, wr_vec(), 0);
    check({tag, "_cnt"}, sample_cnt, 0);
    check({tag, "_sd"}, stan_dev_o, 0);
    check({tag, "_avg"}, avg_o, 0);
    check({tag, "_gamma"}, gamma_o, 0);
    check({tag, "_beta"}, beta_o, 0);
  endtask

  // Fills stim_q with one of the directed sample patterns.
  task automatic fill_stim(input int kind);
    stim_q.delete();
    for (int i = 0; i < MB; i++) begin
      case (kind)
        0:       stim_q.push_back(DW'(i));
        1:       stim_q.push_back((i % 2 == 0) ? 16'hFFFD : 16'h0000);
        2:       stim_q.push_back((i == 17) ? 16'h8000 : 16'h7FFF);
        3:       stim_q.push_back(16'd5);
        4:       stim_q.push_back(16'hFFFF);
        5:       stim_q.push_back(DW'(-i));
        default: stim_q.push_back(16'd7);
      endcase
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string         name;
    int            kind;
    int            stall;
    bit            poke;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_sd;
    logic [DW-1:0] exp_avg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"basic",     0, 0,  1'b0, 16'h0100, 16'hFFF0, 16'd63,   16'd31};
    vecs[1] = '{"alt_neg3",  1, 0,  1'b0, 16'h1234, 16'h5678, 16'd3,    16'hFFFE};
    vecs[2] = '{"saturate",  2, 10, 1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 16'h7BFF};
    vecs[3] = '{"const5",    3, 0,  1'b0, 16'h0001, 16'h0002, 16'd0,    16'd5};
    vecs[4] = '{"const_m1",  4, 20, 1'b0, 16'hFFFF, 16'h0000, 16'd0,    16'hFFFF};
    vecs[5] = '{"neg_ramp",  5, 0,  1'b0, 16'h7FFF, 16'h8000, 16'd63,   16'hFFE0};
    vecs[6] = '{"stall",     0, 68, 1'b1, 16'h0100, 16'hFFF0, 16'd63,   16'd31};

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all_zero("post_reset");

    // Table-driven directed batches (run back to back)
    for (int v = 0; v < 7; v++) begin
      fill_stim(vecs[v].kind);
      exp_q.push_back(vecs[v].exp_sd);
      exp_q.push_back(vecs[v].exp_avg);
      exp_q.push_back(vecs[v].g);
      exp_q.push_back(vecs[v].b);
      run_batch(vecs[v].name, vecs[v].stall, vecs[v].poke, vecs[v].g, vecs[v].b);
    end

    // Randomized batches checked against the model
    for (int r = 0; r < 8; r++) begin
      logic [DW-1:0] g, b;
      stim_q.delete();
      for (int i = 0; i < MB; i++) begin
        if (r % 2 == 0) stim_q.push_back(DW'($urandom));
        else            stim_q.push_back(DW'($urandom_range(40)) - 16'd20);
      end
      g = DW'($urandom);
      b = DW'($urandom);
      model_push(g, b);
      run_batch("random", $urandom_range(60), 1'($urandom_range(1)), g, b);
    end

    // Reset in the middle of ACCUM after 10 samples
    start     = 1'b1;
    gamma_cfg = 16'h4444;
    beta_cfg  = 16'h3333;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x_valid = 1'b1;
      x_data  = DW'($urandom);
      step();
    end
    x_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fill_stim(0);
    model_push(16'h0100, 16'hFFF0);
    run_batch("after_reset", 0, 1'b0, 16'h0100, 16'hFFF0);

`ifdef BN_ABORT_EN
    // Abort after 20 samples. The abort-cycle sample is discarded and nothing is written.
    start     = 1'b1;
    gamma_cfg = 16'h0BAD;
    beta_cfg  = 16'h0BAD;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      x_valid = 1'b1;
      x_data  = DW'($urandom);
      step();
    end
    abort   = 1'b1;
    x_data  = 16'h7FFF;
    step();
    abort   = 1'b0;
    x_valid = 1'b0;
    check("abort_pulse", aborted, 1);
    check("abort_idle", busy, 0);
    check("abort_no_wr", wr_vec(), 0);
    step();
    check("abort_pulse_end", aborted, 0);
    for (int i = 0; i < 8; i++) begin
      check("abort_quiet", wr_vec(), 0);
      step();
    end
    // abort while IDLE has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_idle", aborted, 0);
    fill_stim(6);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd7);
    exp_q.push_back(16'h0007);
    exp_q.push_back(16'h0070);
    run_batch("after_abort", 15, 1'b0, 16'h0007, 16'h0070);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
